data_memory_lines: RTL and testbench

- Parametrised line-granular data memory for the RV32IM pipeline. It serves the data cache's refill and write-back traffic.
- Widths are generalised over line size, depth and address width.
- Read and write latencies are cycle-counted, not fixed delays.
- Adds per-byte write enables, out-of-range and conflicting-request error reporting, and a defined single-cycle completion handshake.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/data_memory_lines_if.sv | 24 ++
 rtl/dmem_line_array.sv | 42 ++++
 rtl/data_memory_lines.sv | 111 +++++++++++
 tb/tb_data_memory_lines.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the line-granular data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned DefLineBytes   = 16;
  localparam int unsigned DefDepthLines  = 16;
  localparam int unsigned DefAddrWidth   = 28;
  localparam int unsigned DefReadCycles  = 4;
  localparam int unsigned DefWriteCycles = 8;

  // Bit offset of byte lane k within a line.
  function automatic int unsigned lane(input int unsigned k);
    return 8 * k;
  endfunction

endpackage

// File: rtl/data_memory_lines_if.sv
// Request/response bus between the data cache and the line memory.
interface data_memory_lines_if #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_WIDTH = 28
) ();
  logic                    read;
  logic                    write;
  logic [ADDR_WIDTH-1:0]   address;
  logic [8*LINE_BYTES-1:0] write_data;
  logic [LINE_BYTES-1:0]   byte_en;
  logic [8*LINE_BYTES-1:0] read_data;
  logic                    busywait;
  logic                    error;

  modport master (
    output read, write, address, write_data, byte_en,
    input  read_data, busywait, error
  );

  modport slave (
    input  read, write, address, write_data, byte_en,
    output read_data, busywait, error
  );
endinterface

// File: rtl/dmem_line_array.sv
// Byte-addressable line storage: async clear, one byte-enabled write port, one comb read port.
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int unsigned LINE_BYTES  = 16,
  parameter int unsigned DEPTH_LINES = 16,
  localparam int unsigned IdxW = $clog2(DEPTH_LINES)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_we,
  input  logic [IdxW-1:0]         i_widx,
  input  logic [8*LINE_BYTES-1:0] i_wdata,
  input  logic [LINE_BYTES-1:0]   i_ben,
  input  logic [IdxW-1:0]         i_ridx,
  output logic [8*LINE_BYTES-1:0] o_rdata
);

  logic [7:0] r_mem [DEPTH_LINES][LINE_BYTES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_LINES; i++) begin
        for (int unsigned k = 0; k < LINE_BYTES; k++) begin
          r_mem[i][k] <= '0;
        end
      end
    end else if (i_we) begin
      for (int unsigned k = 0; k < LINE_BYTES; k++) begin
        if (i_ben[k]) r_mem[i_widx][k] <= i_wdata[lane(k) +: 8];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    for (int unsigned k = 0; k < LINE_BYTES; k++) begin
      o_rdata[lane(k) +: 8] = r_mem[i_ridx][k];
    end
  end

endmodule

// File: rtl/data_memory_lines.sv
// Line-granular data memory with cycle-counted latency, byte enables and fault reporting.
module data_memory_lines
  import dmem_pkg::*;
#(
  parameter int unsigned LINE_BYTES   = DefLineBytes,
  parameter int unsigned DEPTH_LINES  = DefDepthLines,
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned READ_CYCLES  = DefReadCycles,
  parameter int unsigned WRITE_CYCLES = DefWriteCycles
) (
  input  logic              clock,
  input  logic              reset,
  data_memory_lines_if.slave bus
);

  localparam int unsigned IdxW   = $clog2(DEPTH_LINES);
  localparam int unsigned MaxCyc = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  state_e                  r_state, w_state_d;
  logic [CntW-1:0]         r_count, w_count_d;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [8*LINE_BYTES-1:0] r_wdata;
  logic [LINE_BYTES-1:0]   r_ben;
  logic [8*LINE_BYTES-1:0] r_rdata;
  logic [8*LINE_BYTES-1:0] w_line;
  logic                    w_accept;
  logic                    w_in_range;
  logic                    w_we;
  logic                    w_rd_load;

  assign w_in_range    = (r_addr < ADDR_WIDTH'(DEPTH_LINES));
  assign bus.read_data = r_rdata;

  always_comb begin
    w_state_d    = r_state;
    w_count_d    = r_count;
    w_accept     = 1'b0;
    w_we         = 1'b0;
    w_rd_load    = 1'b0;
    bus.busywait = 1'b0;
    bus.error    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.read ^ bus.write) begin
          w_accept     = 1'b1;
          bus.busywait = 1'b1;
          w_state_d    = bus.read ? StRead : StWrite;
          w_count_d    = bus.read ? CntW'(READ_CYCLES - 1) : CntW'(WRITE_CYCLES - 1);
        end else if (bus.read && bus.write) begin
          bus.error = 1'b1;
        end
      end
      StRead, StWrite: begin
        bus.busywait = 1'b1;
        if (r_count == '0) begin
          w_state_d = StDone;
          w_rd_load = (r_state == StRead);
          w_we      = (r_state == StWrite) && w_in_range;
        end else begin
          w_count_d = r_count - CntW'(1);
        end
      end
      StDone: begin
        bus.error = !w_in_range;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Outputs are quiet while reset is held, even if a request is still asserted.
    if (reset) begin
      bus.busywait = 1'b0;
      bus.error    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_count <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ben   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      if (w_accept) begin
        r_addr  <= bus.address;
        r_wdata <= bus.write_data;
        r_ben   <= bus.byte_en;
      end
      if (w_rd_load) r_rdata <= w_in_range ? w_line : '0;
    end
  end

  dmem_line_array #(
    .LINE_BYTES  (LINE_BYTES),
    .DEPTH_LINES (DEPTH_LINES)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .i_we    (w_we),
    .i_widx  (r_addr[IdxW-1:0]),
    .i_wdata (r_wdata),
    .i_ben   (r_ben),
    .i_ridx  (r_addr[IdxW-1:0]),
    .o_rdata (w_line)
  );

endmodule

// File: tb/tb_data_memory_lines.sv
// Directed bench for data_memory_lines: vector table plus multi-cycle corner sequences.
module tb_data_memory_lines;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  data_memory_lines_if #(.LINE_BYTES(16), .ADDR_WIDTH(28)) bus ();

  data_memory_lines #(
    .LINE_BYTES   (16),
    .DEPTH_LINES  (16),
    .ADDR_WIDTH   (28),
    .READ_CYCLES  (4),
    .WRITE_CYCLES (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [15:0]  ben;
    int           cyc;
    logic [127:0] rdata;
    logic         err;
  } vec_t;

  localparam logic [127:0] D  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] E  = 128'h00112233_44556677_8899AABB_AAAAAAAA;
  localparam logic [127:0] X  = 128'h5A123456_789ABCDE_F0123456_789ABCDE;
  localparam logic [127:0] XL = 128'h5A000000_00000000_00000000_00000000;
  localparam logic [127:0] P  = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  vec_t vecs [13];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Starts at a falling edge; returns in the first non-busy cycle (DONE for an accepted access).
  task automatic do_access(input logic wr, input logic [27:0] addr, input logic [127:0] data,
                           input logic [15:0] ben, output int cyc, output logic err_busy);
    bus.read       = !wr;
    bus.write      = wr;
    bus.address    = addr;
    bus.write_data = data;
    bus.byte_en    = ben;
    cyc      = 0;
    err_busy = 1'b0;
    #1;
    while (bus.busywait && cyc < 100) begin
      cyc++;
      if (bus.error) err_busy = 1'b1;
      @(negedge clock);
      #1;
    end
  endtask

  task automatic drop_req();
    bus.read  = 1'b0;
    bus.write = 1'b0;
    @(negedge clock);
  endtask

  task automatic read_line(input string name, input logic [27:0] addr, input logic [127:0] exp);
    int   cyc;
    logic eb;
    do_access(1'b0, addr, '0, '0, cyc, eb);
    check({name, "_cyc"}, 128'(cyc), 128'd5);
    check({name, "_data"}, bus.read_data, exp);
    drop_req();
  endtask

  initial begin
    int   cyc;
    logic eb;

    vecs[0]  = '{1'b0, 28'd3,  '0,            16'h0000, 5, '0, 1'b0};
    vecs[1]  = '{1'b1, 28'd3,  D,             16'hFFFF, 9, '0, 1'b0};
    vecs[2]  = '{1'b0, 28'd3,  '0,            16'h0000, 5, D,  1'b0};
    vecs[3]  = '{1'b1, 28'd3,  {16{8'hAA}},   16'h000F, 9, D,  1'b0};
    vecs[4]  = '{1'b0, 28'd3,  '0,            16'h0000, 5, E,  1'b0};
    vecs[5]  = '{1'b1, 28'd7,  {16{8'hFF}},   16'h0000, 9, E,  1'b0};
    vecs[6]  = '{1'b0, 28'd7,  '0,            16'h0000, 5, '0, 1'b0};
    vecs[7]  = '{1'b1, 28'd16, {16{8'hFF}},   16'hFFFF, 9, '0, 1'b1};
    vecs[8]  = '{1'b0, 28'd0,  '0,            16'h0000, 5, '0, 1'b0};
    vecs[9]  = '{1'b0, 28'd3,  '0,            16'h0000, 5, E,  1'b0};
    vecs[10] = '{1'b0, 28'd16, '0,            16'h0000, 5, '0, 1'b1};
    vecs[11] = '{1'b1, 28'd15, X,             16'h8000, 9, '0, 1'b0};
    vecs[12] = '{1'b0, 28'd15, '0,            16'h0000, 5, XL, 1'b0};

    reset          = 1'b1;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    bus.byte_en    = '0;
    #12;
    check("rst_busy", 128'(bus.busywait), 128'd0);
    check("rst_err", 128'(bus.error), 128'd0);
    check("rst_rdata", bus.read_data, '0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 13; i++) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].ben, cyc, eb);
      check($sformatf("v%0d_cyc", i), 128'(cyc), 128'(vecs[i].cyc));
      check($sformatf("v%0d_err_done", i), 128'(bus.error), 128'(vecs[i].err));
      check($sformatf("v%0d_err_busy", i), 128'(eb), 128'd0);
      check($sformatf("v%0d_rdata", i), bus.read_data, vecs[i].rdata);
      drop_req();
      check($sformatf("v%0d_idle_err", i), 128'(bus.error), 128'd0);
    end

    // Conflicting request: rejected with error while held, memory untouched.
    bus.read       = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 28'd3;
    bus.write_data = '0;
    bus.byte_en    = 16'hFFFF;
    #1;
    check("conf_err0", 128'(bus.error), 128'd1);
    check("conf_busy0", 128'(bus.busywait), 128'd0);
    @(negedge clock);
    #1;
    check("conf_err1", 128'(bus.error), 128'd1);
    check("conf_busy1", 128'(bus.busywait), 128'd0);
    drop_req();
    read_line("conf_mem", 28'd3, E);

    // Request dropped and inputs changed mid-write: access completes from the latched request.
    bus.write      = 1'b1;
    bus.address    = 28'd9;
    bus.write_data = P;
    bus.byte_en    = 16'hFFFF;
    cyc = 0;
    #1;
    if (bus.busywait) cyc++;
    @(negedge clock);
    #1;
    if (bus.busywait) cyc++;
    bus.write      = 1'b0;
    bus.address    = 28'd3;
    bus.write_data = '0;
    @(negedge clock);
    #1;
    while (bus.busywait && cyc < 100) begin
      cyc++;
      @(negedge clock);
      #1;
    end
    check("drop_cyc", 128'(cyc), 128'd9);
    @(negedge clock);
    read_line("drop_line9", 28'd9, P);
    read_line("drop_line3", 28'd3, E);

    // Reset three cycles into a write: busywait drops at once, write discarded, array cleared.
    do_access(1'b1, 28'd5, D, 16'hFFFF, cyc, eb);
    check("pre_rst_busy", 128'(cyc), 128'd9);
    drop_req();
    bus.write      = 1'b1;
    bus.address    = 28'd5;
    bus.write_data = X;
    bus.byte_en    = 16'hFFFF;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 128'(bus.busywait), 128'd0);
    check("mid_rst_rdata", bus.read_data, '0);
    bus.write = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    read_line("rst_line5", 28'd5, '0);
    read_line("rst_line3", 28'd3, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
